pc_rx_cfg_extract: RTL and testbench
====================================

Name: pc_rx_cfg_extract

Overview:
- Parametrised successor to the single-word PC instruction extractor.
- Pops one frame-info record per frame from the frame info FIFO, arbitrates for the frame data BRAM read port, and streams the frame payload out as a sequence of configuration words.
- Word width, maximum words per frame, header skip and frame overhead are all parameters; each word carries an index.
- Flags malformed lengths. Sits between the PC RX frame buffer (BRAM + info FIFO) and the config register bank.

Parameters:
- U_DLY, 1, simulation delay on register assignments.
- ADDR_W, 12, BRAM address width.
- WORD_BYTES, 2, bytes per config word (1..4).
- MAX_WORDS, 8, max config words extracted per frame (1..256).
- HDR_SKIP, 2, bytes between frame start address and first payload byte.
- FRAME_OVH, 17, non-payload bytes counted in the frame length field.

Ports:
- clk_sys  in  1  system clock.
- rst_n  in  1  reset; synchronous to clk_sys, active-low.
- fififo_rd_en  out  1  info FIFO read strobe, one-cycle pulse.
- fififo_rd_data  in  72  info record: [31:0] frame length in bytes; [40+ADDR_W-1:40] frame start address.
- fififo_empty  in  1  info FIFO empty.
- fdram_rd_req  out  1  BRAM read-port request, level.
- fdram_rd_ack  in  1  BRAM read-port grant, one-cycle pulse.
- fdram_rd_done  out  1  release of BRAM read port, one-cycle pulse.
- fdram_rd_addr  out  ADDR_W  BRAM read address.
- fdram_rd_data  in  8  BRAM read data, 1-cycle latency.
- cfg_data  out  8*WORD_BYTES  assembled config word.
- cfg_data_valid  out  1  cfg_data/cfg_word_idx valid, one-cycle pulse.
- cfg_word_idx  out  8  index of the word within its frame, starting at 0.
- cfg_frame_done  out  1  one-cycle pulse after the last word of a frame.
- cfg_len_err  out  1  one-cycle pulse when the frame length is invalid.

Behaviour:
- Reset: all outputs 0 and FSM in IDLE. Reset is synchronous; asserting it mid-frame drops fdram_rd_req the next edge and produces no done, valid or err pulses.
- FSM states: IDLE -> POP -> LATCH -> REQ -> READ -> DONE -> IDLE.
- IDLE: when fififo_empty=0, go to POP.
- POP: fififo_rd_en=1 for exactly this cycle. FIFO data is valid the following cycle.
- LATCH: register the length L and start address S. Compute:
  - P = L - FRAME_OVH (32-bit; L < FRAME_OVH counts as P=0).
  - W = P / WORD_BYTES, then N = min(W, MAX_WORDS).
  - err = (W==0) | (P % WORD_BYTES != 0) | (W > MAX_WORDS).
  - Set fdram_rd_addr = S + HDR_SKIP, modulo 2^ADDR_W.
  - If W==0: pulse cfg_len_err, go to IDLE with no BRAM request.
  - Otherwise go to REQ.
- REQ: hold fdram_rd_req=1 until the cycle fdram_rd_ack=1, then drop it next edge and go to READ. An ack seen in any other state is ignored.
- READ:
  - Issue N*WORD_BYTES consecutive addresses, one per cycle; the address increments and wraps modulo 2^ADDR_W.
  - Byte k is captured the cycle after its address. Bytes are big-endian: the first byte of a word goes to the MSB.
  - cfg_data_valid pulses the cycle after the last byte of each word is captured; cfg_word_idx counts 0..N-1.
  - After the last word's valid pulse, go to DONE.
- DONE: pulse fdram_rd_done and cfg_frame_done together; pulse cfg_len_err in the same cycle if err. Return to IDLE.
- Back-to-back frames: minimum one IDLE cycle between frames; a FIFO pop never overlaps an active frame.
- cfg_data holds its last value between valid pulses.

Test Plan:
- Nominal: S=0x100, L=21, bytes AA BB CC DD at 0x102..0x105, ack 3 cycles after req. Required: exactly 4 reads; 0xAABB idx0, then 0xCCDD idx1; done+frame_done one cycle after the last valid; err=0.
- Address wrap: S=0xFFE, L=21. Required: reads at 0x000, 0x001, 0x002, 0x003.
- Short frame: L=18 (P=1, W=0). Required: cfg_len_err pulse; fdram_rd_req stays 0; no valid pulses.
- Overflow/odd: MAX_WORDS=8, L=37 (W=10). Required: 16 reads, idx0..7, err pulse with done. Also L=22 (P=5). Required: 2 words and err=1.
- Two frames queued in the FIFO, ack delayed 6 cycles each. Required: second pop only after the first done; req held high through the delay; idx restarts at 0.
- Reset asserted during READ after word 0. Required: req and all outputs 0 next edge; no done; a new frame after reset processes normally.

Source files
------------

// File: rtl/pc_rx_cfg_extract.sv
// pc_rx_cfg_extract: pops one frame-info record per frame, reads the
// frame payload from the frame BRAM and emits indexed config words.
//
// Ports:
//   clk_sys, rst_n         clock, synchronous active-low reset
//   fififo_rd_en/_data/_empty   frame info FIFO (1-cycle read latency)
//   fdram_rd_req/_ack/_done     BRAM read-port arbitration
//   fdram_rd_addr/_data         BRAM read port (1-cycle read latency)
//   cfg_data/_valid/word_idx    assembled config word stream
//   cfg_frame_done, cfg_len_err end-of-frame and bad-length pulses
module pc_rx_cfg_extract #(
  parameter int U_DLY      = 1,
  parameter int ADDR_W     = 12,
  parameter int WORD_BYTES = 2,
  parameter int MAX_WORDS  = 8,
  parameter int HDR_SKIP   = 2,
  parameter int FRAME_OVH  = 17
) (
  input  logic                    clk_sys,
  input  logic                    rst_n,
  output logic                    fififo_rd_en,
  input  logic [71:0]             fififo_rd_data,
  input  logic                    fififo_empty,
  output logic                    fdram_rd_req,
  input  logic                    fdram_rd_ack,
  output logic                    fdram_rd_done,
  output logic [ADDR_W-1:0]       fdram_rd_addr,
  input  logic [7:0]              fdram_rd_data,
  output logic [8*WORD_BYTES-1:0] cfg_data,
  output logic                    cfg_data_valid,
  output logic [7:0]              cfg_word_idx,
  output logic                    cfg_frame_done,
  output logic                    cfg_len_err
);

  localparam int DW = 8 * WORD_BYTES;
  localparam logic [31:0] UDLY_V = U_DLY;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LATCH,
    S_REQ,
    S_READ,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic              rd_en_q, rd_en_d;
  logic              req_q, req_d;
  logic              rd_done_q, rd_done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;
  logic              valid_q, valid_d;
  logic [7:0]        idx_q, idx_d;
  logic              fdone_q, fdone_d;
  logic              len_err_q, len_err_d;
  logic              err_q, err_d;
  logic [8:0]        n_q, n_d;
  logic [10:0]       nb_q, nb_d;
  logic [10:0]       issue_q, issue_d;
  logic              cap_q, cap_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [DW-1:0]     shift_q, shift_d;
  logic [8:0]        wcnt_q, wcnt_d;

  // Length decode straight off the FIFO output, used in LATCH.
  logic [31:0]       len_w;
  logic [ADDR_W-1:0] sa_w;
  logic [31:0]       pay_w;
  logic [31:0]       wds_w;
  logic              rem_w;
  logic              ovf_w;
  logic [8:0]        n_w;
  logic [DW-1:0]     asm_w;

  assign len_w = fififo_rd_data[31:0];
  assign sa_w  = fififo_rd_data[40 +: ADDR_W];
  assign pay_w = (len_w >= 32'(FRAME_OVH)) ?
                 (len_w - 32'(FRAME_OVH)) : 32'd0;
  assign wds_w = pay_w / 32'(WORD_BYTES);
  assign rem_w = (pay_w % 32'(WORD_BYTES)) != 32'd0;
  assign ovf_w = wds_w > 32'(MAX_WORDS);
  assign n_w   = ovf_w ? 9'(MAX_WORDS) : wds_w[8:0];

  // Big-endian assembly: earlier bytes shift toward the MSB.
  assign asm_w = DW'({shift_q, fdram_rd_data});

  always_comb begin
    state_d   = state_q;
    rd_en_d   = 1'b0;
    req_d     = req_q;
    rd_done_d = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    idx_d     = idx_q;
    fdone_d   = 1'b0;
    len_err_d = 1'b0;
    err_d     = err_q;
    n_d       = n_q;
    nb_d      = nb_q;
    issue_d   = issue_q;
    cap_d     = 1'b0;
    bcnt_d    = bcnt_q;
    shift_d   = shift_q;
    wcnt_d    = wcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (!fififo_empty) begin
          state_d = S_POP;
          rd_en_d = 1'b1;
        end
      end
      S_POP: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        addr_d  = sa_w + ADDR_W'(HDR_SKIP);
        err_d   = (wds_w == 32'd0) | rem_w | ovf_w;
        n_d     = n_w;
        nb_d    = 11'(n_w) * 11'(WORD_BYTES);
        issue_d = '0;
        bcnt_d  = '0;
        wcnt_d  = '0;
        if (wds_w == 32'd0) begin
          len_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (fdram_rd_ack) begin
          req_d   = 1'b0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        // Issue side: the last address is held so no extra
        // address appears on the bus after the final byte.
        if (issue_q != nb_q) begin
          cap_d   = 1'b1;
          issue_d = issue_q + 11'd1;
          if (issue_q != nb_q - 11'd1) begin
            addr_d = addr_q + 1'b1;
          end
        end
        // Capture side: cap_q marks a byte on fdram_rd_data.
        if (cap_q) begin
          if (bcnt_q == 2'(WORD_BYTES - 1)) begin
            data_d  = asm_w;
            valid_d = 1'b1;
            idx_d   = wcnt_q[7:0];
            wcnt_d  = wcnt_q + 9'd1;
            bcnt_d  = '0;
          end else begin
            shift_d = asm_w;
            bcnt_d  = bcnt_q + 2'd1;
          end
        end
        if (valid_q && (wcnt_q == n_q)) begin
          state_d   = S_DONE;
          rd_done_d = 1'b1;
          fdone_d   = 1'b1;
          len_err_d = err_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rd_en_q   <= 1'b0;
      req_q     <= 1'b0;
      rd_done_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      fdone_q   <= 1'b0;
      len_err_q <= 1'b0;
      err_q     <= 1'b0;
      n_q       <= '0;
      nb_q      <= '0;
      issue_q   <= '0;
      cap_q     <= 1'b0;
      bcnt_q    <= '0;
      shift_q   <= '0;
      wcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      rd_en_q   <= rd_en_d;
      req_q     <= req_d;
      rd_done_q <= rd_done_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      fdone_q   <= fdone_d;
      len_err_q <= len_err_d;
      err_q     <= err_d;
      n_q       <= n_d;
      nb_q      <= nb_d;
      issue_q   <= issue_d;
      cap_q     <= cap_d;
      bcnt_q    <= bcnt_d;
      shift_q   <= shift_d;
      wcnt_q    <= wcnt_d;
    end
  end

  assign fififo_rd_en   = rd_en_q;
  assign fdram_rd_req   = req_q;
  assign fdram_rd_done  = rd_done_q;
  assign fdram_rd_addr  = addr_q;
  assign cfg_data       = data_q;
  assign cfg_data_valid = valid_q;
  assign cfg_word_idx   = idx_q;
  assign cfg_frame_done = fdone_q;
  assign cfg_len_err    = len_err_q;

  logic unused_ok;
  assign unused_ok = ^{fififo_rd_data[39:32],
                       fififo_rd_data[71:40+ADDR_W],
                       UDLY_V};

endmodule

// File: tb/tb_pc_rx_cfg_extract.sv
// tb_pc_rx_cfg_extract: directed vector bench for pc_rx_cfg_extract
// with FIFO, BRAM and read-port arbiter models.
module tb_pc_rx_cfg_extract;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic        fififo_rd_en;
  logic [71:0] fififo_rd_data = '0;
  logic        fififo_empty   = 1'b1;
  logic        fdram_rd_req;
  logic        fdram_rd_ack   = 1'b0;
  logic        fdram_rd_done;
  logic [11:0] fdram_rd_addr;
  logic [7:0]  fdram_rd_data  = '0;
  logic [15:0] cfg_data;
  logic        cfg_data_valid;
  logic [7:0]  cfg_word_idx;
  logic        cfg_frame_done;
  logic        cfg_len_err;

  always #5 clk_sys = ~clk_sys;

  pc_rx_cfg_extract #(
    .U_DLY(1), .ADDR_W(12), .WORD_BYTES(2),
    .MAX_WORDS(8), .HDR_SKIP(2), .FRAME_OVH(17)
  ) dut (
    .clk_sys(clk_sys),
    .rst_n(rst_n),
    .fififo_rd_en(fififo_rd_en),
    .fififo_rd_data(fififo_rd_data),
    .fififo_empty(fififo_empty),
    .fdram_rd_req(fdram_rd_req),
    .fdram_rd_ack(fdram_rd_ack),
    .fdram_rd_done(fdram_rd_done),
    .fdram_rd_addr(fdram_rd_addr),
    .fdram_rd_data(fdram_rd_data),
    .cfg_data(cfg_data),
    .cfg_data_valid(cfg_data_valid),
    .cfg_word_idx(cfg_word_idx),
    .cfg_frame_done(cfg_frame_done),
    .cfg_len_err(cfg_len_err)
  );

  // BRAM model, 1-cycle read latency.
  logic [7:0] mem [0:4095];
  always @(posedge clk_sys) fdram_rd_data <= mem[fdram_rd_addr];

  // Info FIFO model, data valid the cycle after the pop.
  logic [71:0] fifo_q [$];
  always @(posedge clk_sys) begin
    if (fififo_rd_en && fifo_q.size() > 0)
      fififo_rd_data <= fifo_q.pop_front();
    fififo_empty <= (fifo_q.size() == 0);
  end

  // Arbiter model: ack pulses ack_dly cycles after req rises.
  int ack_dly = 3;
  int ack_cnt = 0;
  always @(posedge clk_sys) begin
    fdram_rd_ack <= 1'b0;
    if (fdram_rd_req && !fdram_rd_ack) begin
      if (ack_cnt >= ack_dly - 1) begin
        fdram_rd_ack <= 1'b1;
        ack_cnt <= 0;
      end else begin
        ack_cnt <= ack_cnt + 1;
      end
    end else begin
      ack_cnt <= 0;
    end
  end

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Event logs, sampled away from the active edge.
  logic [15:0] v_data [$];
  logic [7:0]  v_idx  [$];
  int          v_cyc  [$];
  int          d_cyc  [$];
  int          e_cyc  [$];
  int          p_cyc  [$];
  logic [11:0] a_log  [$];
  int          req_cnt = 0;
  int          fd_mis  = 0;
  logic        rd_win  = 1'b0;
  logic        first_w = 1'b0;
  logic [11:0] last_a  = '0;

  always @(negedge clk_sys) begin
    if (cfg_data_valid) begin
      v_data.push_back(cfg_data);
      v_idx.push_back(cfg_word_idx);
      v_cyc.push_back(cyc);
    end
    if (fdram_rd_done) d_cyc.push_back(cyc);
    if (fdram_rd_done != cfg_frame_done) fd_mis = fd_mis + 1;
    if (cfg_len_err) e_cyc.push_back(cyc);
    if (fififo_rd_en) p_cyc.push_back(cyc);
    if (fdram_rd_req) req_cnt = req_cnt + 1;
    if (rd_win) begin
      if (first_w || fdram_rd_addr != last_a) begin
        a_log.push_back(fdram_rd_addr);
        last_a = fdram_rd_addr;
      end
      first_w = 1'b0;
    end
    if (fdram_rd_done || !rst_n) begin
      rd_win = 1'b0;
    end else if (fdram_rd_ack) begin
      rd_win  = 1'b1;
      first_w = 1'b1;
    end
  end

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] len;
    logic [11:0] sa;
    int          ack;
    int          nw;
    int          nrd;
    logic        err;
    logic [11:0] a_first;
    logic [11:0] a_last;
    logic [15:0] w_first;
    logic [15:0] w_last;
  } vec_t;

  vec_t tab [9];

  task automatic push_frame(input logic [31:0] len,
                            input logic [11:0] sa);
    logic [71:0] rec;
    rec = '0;
    rec[31:0]  = len;
    rec[51:40] = sa;
    fifo_q.push_back(rec);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int  v0, d0, e0, a0, p0, r0, f0;
    bit  got;
    string t;
    t  = $sformatf("v%0d", id);
    v0 = v_data.size();
    d0 = d_cyc.size();
    e0 = e_cyc.size();
    a0 = a_log.size();
    p0 = p_cyc.size();
    r0 = req_cnt;
    f0 = fd_mis;
    ack_dly = v.ack;
    push_frame(v.len, v.sa);
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk_sys);
      if (v.nw > 0 && d_cyc.size() > d0) got = 1'b1;
      if (v.nw == 0 && e_cyc.size() > e0) got = 1'b1;
      if (got) break;
    end
    repeat (6) @(posedge clk_sys);
    #1;
    check({t, "_finished"}, 32'(got), 1);
    check({t, "_nwords"}, v_data.size() - v0, v.nw);
    check({t, "_errs"}, e_cyc.size() - e0, v.err ? 1 : 0);
    check({t, "_pops"}, p_cyc.size() - p0, 1);
    check({t, "_done_pair"}, fd_mis - f0, 0);
    check({t, "_nreads"}, a_log.size() - a0, v.nrd);
    if (v.nw == 0) begin
      check({t, "_dones"}, d_cyc.size() - d0, 0);
      check({t, "_req_cyc"}, req_cnt - r0, 0);
    end else begin
      check({t, "_dones"}, d_cyc.size() - d0, 1);
      check({t, "_req_cyc"}, req_cnt - r0, v.ack + 1);
      if (v_data.size() >= v0 + v.nw &&
          d_cyc.size() > d0 &&
          a_log.size() >= a0 + v.nrd) begin
        check({t, "_w_first"}, 32'(v_data[v0]), 32'(v.w_first));
        check({t, "_w_last"}, 32'(v_data[v0 + v.nw - 1]),
              32'(v.w_last));
        for (int i = 0; i < v.nw; i++)
          check($sformatf("%s_idx%0d", t, i),
                32'(v_idx[v0 + i]), i);
        check({t, "_done_lat"},
              d_cyc[d0] - v_cyc[v0 + v.nw - 1], 1);
        check({t, "_a_first"}, 32'(a_log[a0]), 32'(v.a_first));
        check({t, "_a_last"}, 32'(a_log[a0 + v.nrd - 1]),
              32'(v.a_last));
        if (v.err)
          check({t, "_err_with_done"}, e_cyc[e0], d_cyc[d0]);
      end
    end
  endtask

  task automatic check_all_zero(input string t);
    check({t, "_rd_en"}, 32'(fififo_rd_en), 0);
    check({t, "_req"}, 32'(fdram_rd_req), 0);
    check({t, "_rd_done"}, 32'(fdram_rd_done), 0);
    check({t, "_addr"}, 32'(fdram_rd_addr), 0);
    check({t, "_data"}, 32'(cfg_data), 0);
    check({t, "_valid"}, 32'(cfg_data_valid), 0);
    check({t, "_idx"}, 32'(cfg_word_idx), 0);
    check({t, "_fdone"}, 32'(cfg_frame_done), 0);
    check({t, "_len_err"}, 32'(cfg_len_err), 0);
  endtask

  initial begin
    int v0, d0, e0, p0, r0;
    bit got;

    for (int a = 0; a < 4096; a++) mem[a] = 8'(a);
    mem[12'h102] = 8'hAA;
    mem[12'h103] = 8'hBB;
    mem[12'h104] = 8'hCC;
    mem[12'h105] = 8'hDD;

    //        len           sa     ack nw nrd err afirst alast  wfirst    wlast
    tab[0] = '{32'd21, 12'h100, 3, 2, 4, 1'b0, 12'h102, 12'h105,
               16'hAABB, 16'hCCDD};
    tab[1] = '{32'd21, 12'hFFE, 2, 2, 4, 1'b0, 12'h000, 12'h003,
               16'h0001, 16'h0203};
    tab[2] = '{32'd18, 12'h100, 3, 0, 0, 1'b1, 12'h000, 12'h000,
               16'h0000, 16'h0000};
    tab[3] = '{32'd37, 12'h200, 1, 8, 16, 1'b1, 12'h202, 12'h211,
               16'h0203, 16'h1011};
    tab[4] = '{32'd22, 12'h300, 4, 2, 4, 1'b1, 12'h302, 12'h305,
               16'h0203, 16'h0405};
    tab[5] = '{32'd10, 12'h100, 1, 0, 0, 1'b1, 12'h000, 12'h000,
               16'h0000, 16'h0000};
    tab[6] = '{32'd33, 12'h0F0, 2, 8, 16, 1'b0, 12'h0F2, 12'h101,
               16'hF2F3, 16'h0001};
    tab[7] = '{32'd19, 12'h7FD, 1, 1, 2, 1'b0, 12'h7FF, 12'h800,
               16'hFF00, 16'hFF00};
    tab[8] = '{32'hFFFF_FFFF, 12'h000, 2, 8, 16, 1'b1, 12'h002,
               12'h011, 16'h0203, 16'h1011};

    rst_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;

    for (int i = 0; i < 9; i++) run_vec(tab[i], i);

    // Two queued frames with a slow arbiter.
    v0 = v_data.size();
    d0 = d_cyc.size();
    e0 = e_cyc.size();
    p0 = p_cyc.size();
    r0 = req_cnt;
    ack_dly = 6;
    push_frame(32'd21, 12'h100);
    push_frame(32'd22, 12'h300);
    got = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk_sys);
      if (d_cyc.size() >= d0 + 2) begin
        got = 1'b1;
        break;
      end
    end
    repeat (6) @(posedge clk_sys);
    #1;
    check("2f_finished", 32'(got), 1);
    check("2f_pops", p_cyc.size() - p0, 2);
    check("2f_words", v_data.size() - v0, 4);
    check("2f_req_cyc", req_cnt - r0, 14);
    check("2f_errs", e_cyc.size() - e0, 1);
    if (got && p_cyc.size() >= p0 + 2 &&
        v_data.size() >= v0 + 4 && e_cyc.size() > e0) begin
      check("2f_pop_after_done",
            32'(p_cyc[p0 + 1] > d_cyc[d0]), 1);
      check("2f_w0", 32'(v_data[v0]), 32'h0000AABB);
      check("2f_w1", 32'(v_data[v0 + 1]), 32'h0000CCDD);
      check("2f_w2", 32'(v_data[v0 + 2]), 32'h00000203);
      check("2f_w3", 32'(v_data[v0 + 3]), 32'h00000405);
      check("2f_i1", 32'(v_idx[v0 + 1]), 1);
      check("2f_i2_restart", 32'(v_idx[v0 + 2]), 0);
      check("2f_i3", 32'(v_idx[v0 + 3]), 1);
      check("2f_err_with_done", e_cyc[e0], d_cyc[d0 + 1]);
    end

    // Reset in the middle of a 16-byte read.
    v0 = v_data.size();
    d0 = d_cyc.size();
    e0 = e_cyc.size();
    ack_dly = 1;
    push_frame(32'd37, 12'h200);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_sys);
      #1;
      if (cfg_data_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("rst_word0_seen", 32'(got), 1);
    check("rst_word0_data", 32'(cfg_data), 32'h00000203);
    rst_n = 1'b0;
    @(negedge clk_sys);
    #1;
    check_all_zero("midrst");
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (30) @(posedge clk_sys);
    #1;
    check("rst_no_done", d_cyc.size() - d0, 0);
    check("rst_no_err", e_cyc.size() - e0, 0);
    check("rst_one_word", v_data.size() - v0, 1);

    run_vec(tab[0], 90);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
